// File: rtl/aes_key_sched.sv
// AES key schedule: loads a 128/192/256-bit key, expands it one word per cycle into a
// word store, and streams round keys in encrypt or decrypt order, with optional replay.
module aes_key_sched #(
    parameter int NK_MAX    = 8,
    parameter bit REPLAY_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         KeyValid,
    input  logic [0:255] Key,
    input  logic [3:0]   Nk,
    input  logic         Dir,
    input  logic         Replay,
    input  logic         RkReq,
    output logic         RkValid,
    output logic [0:127] RoundKey,
    output logic [3:0]   Round,
    output logic         Busy,
    output logic         Done,
    output logic         KeyErr
);

    localparam int DEPTH = 4 * (NK_MAX + 7);
    localparam int AW    = $clog2(DEPTH + 1);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, STREAM} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    nk_q, nk_d, nr_q, nr_d;
    logic [3:0]    rd_round_q, rd_round_d, mod_cnt_q, mod_cnt_d;
    logic          dir_q, dir_d, sched_vld_q, sched_vld_d;
    logic          done_q, done_d, key_err_q, key_err_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [0:255]  key_q;
    logic [31:0]   mem [DEPTH];

    logic          in_idle, nk_ok, rep_ok, accept_key, accept_rep, reject;
    logic [AW-1:0] base, last_idx;
    logic [31:0]   prev_w, back_w, temp, new_w;
    logic          rk_vld, xfer, last_round;

    always_comb begin
        in_idle    = (state_q == IDLE);
        nk_ok      = ((Nk == 4'd4) || (Nk == 4'd6) || (Nk == 4'd8)) && (int'(Nk) <= NK_MAX);
        rep_ok     = REPLAY_EN && sched_vld_q;
        accept_key = in_idle && KeyValid && nk_ok;
        accept_rep = in_idle && !KeyValid && Replay && rep_ok;
        reject     = in_idle && ((KeyValid && !nk_ok) || (!KeyValid && Replay && !rep_ok));
    end

    // Next word of the recurrence; mod_cnt_q tracks i mod Nk without a divider.
    always_comb begin
        prev_w = mem[wr_idx_q - AW'(1)];
        back_w = mem[wr_idx_q - AW'(nk_q)];
        if (mod_cnt_q == 4'd0) begin
            temp = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
        end else if ((nk_q == 4'd8) && (mod_cnt_q == 4'd4)) begin
            temp = sub_word(prev_w);
        end else begin
            temp = prev_w;
        end
        new_w = back_w ^ temp;
    end

    always_comb begin
        base     = AW'({rd_round_q, 2'b00});
        last_idx = AW'({nr_q, 2'b11});
        case (state_q)
            EXPAND:  rk_vld = !dir_q && (wr_idx_q > base + AW'(3));
            STREAM:  rk_vld = 1'b1;
            default: rk_vld = 1'b0;
        endcase
        xfer       = rk_vld && RkReq;
        last_round = dir_q ? (rd_round_q == 4'd0) : (rd_round_q == nr_q);
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        nk_d        = nk_q;
        nr_d        = nr_q;
        dir_d       = dir_q;
        rd_round_d  = rd_round_q;
        mod_cnt_d   = mod_cnt_q;
        rcon_d      = rcon_q;
        wr_idx_d    = wr_idx_q;
        sched_vld_d = sched_vld_q;
        done_d      = 1'b0;
        key_err_d   = reject;
        case (state_q)
            IDLE: begin
                if (accept_key) begin
                    state_d     = LOAD;
                    nk_d        = Nk;
                    nr_d        = Nk + 4'd6;
                    dir_d       = Dir;
                    rd_round_d  = Dir ? (Nk + 4'd6) : 4'd0;
                    sched_vld_d = 1'b0;
                end else if (accept_rep) begin
                    state_d    = STREAM;
                    dir_d      = Dir;
                    rd_round_d = Dir ? nr_q : 4'd0;
                end
            end
            LOAD: begin
                state_d   = EXPAND;
                wr_idx_d  = AW'(nk_q);
                mod_cnt_d = 4'd0;
                rcon_d    = 8'h01;
            end
            EXPAND: begin
                wr_idx_d  = wr_idx_q + AW'(1);
                mod_cnt_d = (mod_cnt_q == nk_q - 4'd1) ? 4'd0 : mod_cnt_q + 4'd1;
                if (mod_cnt_q == 4'd0) rcon_d = xtime(rcon_q);
                if (wr_idx_q == last_idx) begin
                    state_d     = STREAM;
                    sched_vld_d = 1'b1;
                end
            end
            default: ;
        endcase
        // The final round only exists once expansion is complete, so this never races EXPAND.
        if (xfer) begin
            if (last_round) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                rd_round_d = dir_q ? rd_round_q - 4'd1 : rd_round_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            nk_q        <= 4'd4;
            nr_q        <= 4'd10;
            dir_q       <= 1'b0;
            rd_round_q  <= 4'd0;
            mod_cnt_q   <= 4'd0;
            rcon_q      <= 8'h01;
            wr_idx_q    <= '0;
            sched_vld_q <= 1'b0;
            done_q      <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            nk_q        <= nk_d;
            nr_q        <= nr_d;
            dir_q       <= dir_d;
            rd_round_q  <= rd_round_d;
            mod_cnt_q   <= mod_cnt_d;
            rcon_q      <= rcon_d;
            wr_idx_q    <= wr_idx_d;
            sched_vld_q <= sched_vld_d;
            done_q      <= done_d;
            key_err_q   <= key_err_d;
        end
    end

    // NOTE: key register and word store are deliberately not reset; state and flags gate every use.
    always_ff @(posedge clk) begin
        if (accept_key) key_q <= Key;
        if (state_q == LOAD) begin
            for (int j = 0; j < NK_MAX; j++) begin
                if (j < int'(nk_q)) mem[AW'(j)] <= key_q[32*j +: 32];
            end
        end
        if (state_q == EXPAND) mem[wr_idx_q] <= new_w;
    end

    assign RkValid  = rk_vld;
    assign RoundKey = rk_vld ? {mem[base], mem[base + AW'(1)], mem[base + AW'(2)], mem[base + AW'(3)]} : '0;
    assign Round    = rk_vld ? rd_round_q : 4'd0;
    assign Busy     = (state_q != IDLE);
    assign Done     = done_q;
    assign KeyErr   = key_err_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched: stimulus pushes expected round keys, a negedge
// monitor compares every presented key, stall stability and Done/KeyErr pulses.
module tb_aes_key_sched;

    localparam logic [0:255] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [0:255] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [0:255] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:255] KFIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         KeyValid, Dir, Replay, RkReq;
    logic [0:255] Key;
    logic [3:0]   Nk;
    logic         RkValid, Busy, Done, KeyErr;
    logic [0:127] RoundKey;
    logic [3:0]   Round;

    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    int           kerr_cnt = 0;
    bit           rand_en = 1'b0;
    exp_t         exp_q[$];
    logic [127:0] got_rk [0:14];
    logic [7:0]   sbox_t [256];
    logic [31:0]  mw [0:59];

    aes_key_sched dut (
        .clk(clk), .rst(rst), .KeyValid(KeyValid), .Key(Key), .Nk(Nk), .Dir(Dir),
        .Replay(Replay), .RkReq(RkReq), .RkValid(RkValid), .RoundKey(RoundKey),
        .Round(Round), .Busy(Busy), .Done(Done), .KeyErr(KeyErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference S-box derived from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(x));
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [0:255] k, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) mw[i] = k[32*i +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                repeat (i / nk - 1) rc = gmul(rc, 8'h02);
                t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_w(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    task automatic push_rounds(input int nr, input bit dir);
        exp_t e;
        for (int n = 0; n <= nr; n++) begin
            e.rnd = dir ? 4'(nr - n) : 4'(n);
            e.key = {mw[4*e.rnd], mw[4*e.rnd+1], mw[4*e.rnd+2], mw[4*e.rnd+3]};
            exp_q.push_back(e);
        end
    endtask

    // Returns 1ns after the accepting edge E0.
    task automatic issue_key(input logic [0:255] k, input logic [3:0] nk, input bit dir);
        @(posedge clk); #1;
        KeyValid = 1'b1; Key = k; Nk = nk; Dir = dir;
        @(posedge clk); #1;
        KeyValid = 1'b0;
    endtask

    task automatic issue_replay(input bit dir);
        @(posedge clk); #1;
        Replay = 1'b1; Dir = dir;
        @(posedge clk); #1;
        Replay = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk); #1;
            if (Done) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_queue_empty"}, exp_q.size() == 0, 1);
    endtask

    // Random consumer readiness, driven well clear of the sampling edge.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_en) RkReq = 1'($urandom_range(0, 1));
        end
    end

    bit           prev_stall = 1'b0;
    bit           exp_done = 1'b0;
    logic [127:0] prev_key;
    logic [3:0]   prev_rnd;

    always @(negedge clk) begin
        if (exp_done) begin
            check("done_after_final", Done, 1);
            check("rkvalid_low_in_done", RkValid, 0);
            exp_done = 1'b0;
        end
        if (Done) done_cnt++;
        if (KeyErr) kerr_cnt++;
        if (prev_stall) begin
            check("stall_valid_held", RkValid, 1);
            check("stall_key_stable", RoundKey, prev_key);
            check("stall_round_stable", Round, prev_rnd);
        end
        prev_stall = 1'b0;
        if (RkValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rkvalid", RkValid, 0);
            end else begin
                check("round_index", Round, exp_q[0].rnd);
                check("round_key", RoundKey, exp_q[0].key);
                if (RkReq) begin
                    got_rk[Round] = RoundKey;
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) exp_done = 1'b1;
                end else begin
                    prev_stall = 1'b1;
                    prev_key   = RoundKey;
                    prev_rnd   = Round;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, k0;
        logic [0:255] rk;
        rst = 1'b0; KeyValid = 1'b0; Key = '0; Nk = 4'd4; Dir = 1'b0; Replay = 1'b0; RkReq = 1'b0;
        init_sbox();
        #3;
        check("rst_rkvalid", RkValid, 0);
        check("rst_roundkey", RoundKey, 0);
        check("rst_round", Round, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_keyerr", KeyErr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // AES-128 encrypt, consumer always ready.
        RkReq = 1'b1;
        model_expand(K128, 4);
        push_rounds(10, 1'b0);
        issue_key(K128, 4'd4, 1'b0);
        check("a128_busy_e0", Busy, 1);
        check("a128_rkvalid_e0", RkValid, 0);
        @(posedge clk); #1;
        check("a128_r0_valid_e1", RkValid, 1);
        check("a128_r0_round_e1", Round, 0);
        wait_done(200, "a128");
        check("a128_r0_key", got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
        check("a128_r1_key", got_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("a128_r10_key", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // AES-192 decrypt: nothing until the last word lands at E47.
        model_expand(K192, 6);
        push_rounds(12, 1'b1);
        issue_key(K192, 4'd6, 1'b1);
        repeat (46) @(posedge clk);
        #1 check("a192_no_valid_e46", RkValid, 0);
        @(posedge clk); #1;
        check("a192_valid_e47", RkValid, 1);
        check("a192_round_e47", Round, 12);
        check("a192_key_e47", RoundKey, 128'ha4970a331a78dc09c418c271e3a41d5d);
        wait_done(100, "a192");
        check("a192_r0_key", got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);

        // AES-256 decrypt, then replay in encrypt order.
        model_expand(K256, 8);
        push_rounds(14, 1'b1);
        issue_key(K256, 4'd8, 1'b1);
        repeat (52) @(posedge clk);
        #1 check("a256_no_valid_e52", RkValid, 0);
        @(posedge clk); #1;
        check("a256_valid_e53", RkValid, 1);
        check("a256_round_e53", Round, 14);
        check("a256_key_e53", RoundKey, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        wait_done(100, "a256_dec");
        push_rounds(14, 1'b0);
        issue_replay(1'b0);
        check("replay_valid_next_edge", RkValid, 1);
        check("replay_round0", Round, 0);
        check("replay_key0", RoundKey, 128'h000102030405060708090a0b0c0d0e0f);
        wait_done(100, "a256_replay");
        check("replay_r14_key", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Random consumer stalls across key sizes and directions.
        rand_en = 1'b1;
        model_expand(KFIPS, 4);
        push_rounds(10, 1'b0);
        issue_key(KFIPS, 4'd4, 1'b0);
        wait_done(400, "rand_fips");
        check("rand_fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int c = 0; c < 3; c++) begin
            for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom();
            model_expand(rk, 6 + 2 * (c % 2));
            push_rounds(12 + 2 * (c % 2), 1'(c == 1));
            issue_key(rk, 4'(6 + 2 * (c % 2)), 1'(c == 1));
            wait_done(400, "rand_cfg");
        end
        rand_en = 1'b0;
        @(posedge clk); #1 RkReq = 1'b1;

        // Rejected requests after reset, then requests ignored while busy.
        rst = 1'b0;
        #2 rst = 1'b1;
        k0 = kerr_cnt;
        issue_key(K128, 4'd5, 1'b0);
        check("nk5_keyerr", KeyErr, 1);
        check("nk5_idle", Busy, 0);
        @(posedge clk); #1 check("nk5_pulse_one_cycle", KeyErr, 0);
        issue_replay(1'b0);
        check("replay_empty_keyerr", KeyErr, 1);
        check("replay_empty_idle", Busy, 0);
        check("replay_empty_no_valid", RkValid, 0);
        model_expand(K128, 4);
        push_rounds(10, 1'b1);
        issue_key(K128, 4'd4, 1'b1);
        KeyValid = 1'b1; Key = K256; Nk = 4'd8; Dir = 1'b0; Replay = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("busy_req_no_keyerr", KeyErr, 0);
            check("busy_req_still_busy", Busy, 1);
        end
        KeyValid = 1'b0; Replay = 1'b0;
        wait_done(100, "busy_ignore");
        check("keyerr_count", kerr_cnt - k0, 2);

        // Reset in the middle of expansion aborts without Done.
        issue_key(K128, 4'd4, 1'b1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        d0 = done_cnt;
        #1;
        check("abort_rkvalid", RkValid, 0);
        check("abort_roundkey", RoundKey, 0);
        check("abort_round", Round, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_keyerr", KeyErr, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (60) @(posedge clk);
        #1 check("abort_no_done", done_cnt, d0);
        issue_replay(1'b0);
        check("abort_replay_keyerr", KeyErr, 1);
        check("abort_replay_idle", Busy, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 The block SHALL have parameter NK_MAX, default 8, giving the largest supported Nk (legal values 4, 6, 8); the word store depth SHALL be 4*(NK_MAX+7).
REQ-002 The block SHALL have parameter REPLAY_EN, default 1, which enables the Replay request.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port KeyValid, input, 1 bit: when high, start expansion of Key.
REQ-006 Port Key, input, [0:255]: cipher key, MSB-first; only Key[0:32*Nk-1] is used.
REQ-007 Port Nk, input, [3:0]: key length in 32-bit words (4, 6 or 8).
REQ-008 Port Dir, input, 1 bit: output order; 0 = encrypt (round 0..Nr), 1 = decrypt (round Nr..0).
REQ-009 Port Replay, input, 1 bit: re-emit the stored schedule in the order given by Dir, without re-expanding.
REQ-010 Port RkReq, input, 1 bit: consumer is ready to take a round key.
REQ-011 Port RkValid, output, 1 bit: RoundKey and Round are valid.
REQ-012 Port RoundKey, output, [0:127]: round key words w[4r..4r+3].
REQ-013 Port Round, output, [3:0]: round index r of RoundKey.
REQ-014 Port Busy, output, 1 bit: the block is not IDLE.
REQ-015 Port Done, output, 1 bit: one-cycle pulse after the last round-key transfer.
REQ-016 Port KeyErr, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-017 States SHALL be IDLE, LOAD, EXPAND and STREAM.
- IDLE->LOAD on a legal KeyValid.
- LOAD->EXPAND.
- EXPAND->STREAM after the last word is written.
- STREAM->IDLE on the cycle Done pulses.
REQ-018 A request SHALL be sampled only in IDLE; KeyValid and Replay SHALL be ignored while Busy.
- If KeyValid and Replay are high together, KeyValid SHALL win.
REQ-019 Nr SHALL equal Nk+6, latched together with Nk, Key and Dir when KeyValid is accepted.
- Dir SHALL also be latched when Replay is accepted.
REQ-020 KeyErr SHALL pulse for one cycle and the block SHALL stay in IDLE in each of these cases:
- KeyValid with Nk not in {4, 6, 8}, or Nk > NK_MAX.
- Replay with REPLAY_EN=0.
- Replay with no valid stored schedule.
REQ-021 Timing, with the accepted request sampled at edge E0:
- LOAD SHALL write w[0..Nk-1] at E1.
- EXPAND SHALL write one word w[i] per edge, i = Nk .. 4*Nr+3; word i is written at edge E(i-Nk+2).
REQ-022 Word recurrence, with temp = w[i-1]:
- If i mod Nk = 0: temp = SubWord(RotWord(temp)) xor {Rcon, 24'h0}.
- Else if Nk = 8 and i mod Nk = 4: temp = SubWord(temp).
- Then w[i] = w[i-Nk] xor temp.
REQ-023 Rcon SHALL step 01,02,04,08,10,20,40,80,1b,36 and be tracked by a mod-Nk counter; no divider SHALL be used.
REQ-024 Encrypt order (Dir=0): RkValid SHALL assert once w[4r+3] is written.
- Round 0 SHALL be valid after E1.
- Later rounds SHALL stream concurrently with EXPAND.
REQ-025 Decrypt order (Dir=1): RkValid SHALL first assert after the last word is written.
- Edge E41 for Nk=4, E47 for Nk=6, E53 for Nk=8.
- Round = Nr first, then descending to 0.
REQ-026 A transfer SHALL occur on each edge where RkValid and RkReq are both high.
- While RkValid=1 and RkReq=0, RoundKey and Round SHALL hold stable.
- The next key SHALL be presented the cycle after a transfer whenever its words exist, giving 1 key/cycle throughput.
REQ-027 In encrypt order, if the consumer overtakes expansion, RkValid SHALL drop until words 4r..4r+3 exist; it SHALL never present incomplete words.
REQ-028 Done SHALL pulse one cycle after the transfer of the final key (round Nr for encrypt, round 0 for decrypt), and RkValid SHALL be 0 in that cycle.
REQ-029 An accepted Replay SHALL go directly to STREAM with RkValid asserted on the next edge, with zero expansion cycles.
REQ-030 The stored schedule SHALL be marked valid on completion of EXPAND and invalidated when a new KeyValid is accepted.

Reset
REQ-031 On rst low, outputs SHALL immediately become RkValid=0, RoundKey=0, Round=0, Busy=0, Done=0, KeyErr=0, the state SHALL become IDLE, and the stored-schedule valid flag SHALL clear; word-store contents need not be cleared.
REQ-032 Reset asserted mid-EXPAND or mid-STREAM SHALL abort the operation with no Done pulse, and a subsequent Replay SHALL give KeyErr.

Verification
REQ-033 AES-128, Key=000102030405060708090a0b0c0d0e0f, Nk=4, Dir=0, RkReq=1 -> round 0 = key, round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, round 10 = 13111d7fe3944a17f307a78b4d2b30c5, then Done.
REQ-034 AES-192, Key=00..17, Nk=6, Dir=1 -> first RkValid after E47 with Round=12 and key a4970a331a78dc09c418c271e3a41d5d, last key Round=0 = 0001..0f.
REQ-035 AES-256, Key=00..1f, Nk=8, Dir=1 -> Round=14 key 24fc79ccbf0979e9371ac23c6d68de36 after E53, then Replay with Dir=0 -> rounds 0..14 starting the edge after Replay, in ascending order, with identical keys.
REQ-036 Random RkReq toggling -> RoundKey and Round stable while stalled, no key skipped or duplicated, and output compared against a reference model.
REQ-037 Nk=5, then Replay before any expansion, then KeyValid while Busy -> KeyErr pulses for the first two cases, the third is ignored, and the state is unchanged.
REQ-038 rst low during EXPAND (Nk=4) -> all outputs 0 immediately, no Done, and a following Replay gives KeyErr.
